// File: rtl/mem_stage_sb.sv
// mem_stage_sb: memory-stage front end for a multi-cycle, handshaked data memory.
// Stores retire into a FIFO store buffer that drains in the background; loads
// take the memory port ahead of buffered stores and stall the pipeline until
// their data returns.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ex_valid                 memory-stage slot holds a valid instruction
//   mem_read, mem_write      load / store (both set = load, write ignored)
//   addr, wdata              effective address, store data
//   stall                    combinational hold request to the hazard unit
//   rdata, rdata_valid       registered load result, 1-cycle valid pulse
//   mem_req, mem_we,
//   mem_addr, mem_wdata      registered memory request, held until ack
//   mem_ack, mem_rdata       1-cycle completion pulse, read data
//   sb_count                 store-buffer occupancy
//
// Build option: define MEM_STORE_FWD_EN to serve loads that hit the store
// buffer directly from the youngest matching entry. Without it, such loads
// wait until every matching entry has drained and then read memory.
//
// state      | meaning
// IDLE       | port free; pick a load (priority) or the buffer head
// LOAD_WAIT  | load request outstanding, waiting for mem_ack
// STORE_WAIT | head store request outstanding, waiting for mem_ack
module mem_stage_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ex_valid,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           wdata,
  output logic                        stall,
  output logic [DATA_W-1:0]           rdata,
  output logic                        rdata_valid,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(SB_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              load_done;

  logic is_load;
  logic is_store;
  logic full;
  logic pop;
  logic enq;
  logic load_pend;
  logic match;
  logic issue_load;
  logic drain_ok;
`ifdef MEM_STORE_FWD_EN
  logic [DATA_W-1:0] match_data;
`endif

  // A load with mem_write also set is a load; the write half is dropped.
  assign is_load   = ex_valid & mem_read;
  assign is_store  = ex_valid & mem_write & ~mem_read;
  assign full      = (sb_count == FULL_CNT);
  assign pop       = (state == STORE_WAIT) & mem_ack;
  // A full buffer still accepts a store on the edge that pops the head.
  assign enq       = is_store & (~full | pop);
  assign load_pend = is_load & ~load_done;
  assign stall     = load_pend | (is_store & full & ~pop);

  // Walk valid entries oldest to youngest so the youngest match wins.
  always_comb begin
    match = 1'b0;
`ifdef MEM_STORE_FWD_EN
    match_data = '0;
`endif
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (((PTR_W+1)'(k) < sb_count) && (sb_addr[head + PTR_W'(k)] == addr)) begin
        match = 1'b1;
`ifdef MEM_STORE_FWD_EN
        match_data = sb_data[head + PTR_W'(k)];
`endif
      end
    end
  end

  // A load that hits the buffer never goes to memory until the hit clears
  // (non-forwarding) or is answered from the buffer (forwarding).
  assign issue_load = load_pend & ~match;
  // Draining continues while a hitting load waits, otherwise it would never clear.
  assign drain_ok   = (sb_count != '0) & ~issue_load;

  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr[tail] <= addr;
      sb_data[tail] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      sb_count    <= '0;
      load_done   <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      rdata_valid <= 1'b0;
      if (!stall) load_done <= 1'b0;

      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      case ({enq, pop})
        2'b10:   sb_count <= sb_count + 1'b1;
        2'b01:   sb_count <= sb_count - 1'b1;
        default: ;
      endcase

`ifdef MEM_STORE_FWD_EN
      if (load_pend && match) begin
        load_done   <= 1'b1;
        rdata       <= match_data;
        rdata_valid <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (issue_load) begin
            state     <= LOAD_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= addr;
            mem_wdata <= '0;
          end else if (drain_ok) begin
            state     <= STORE_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= sb_addr[head];
            mem_wdata <= sb_data[head];
          end
        end
        LOAD_WAIT: begin
          if (mem_ack) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            rdata       <= mem_rdata;
            rdata_valid <= 1'b1;
            load_done   <= 1'b1;
          end
        end
        STORE_WAIT: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sb.sv
module tb_mem_stage_sb;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int SB_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, mem_read, mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              stall;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        sb_count;

  int errors = 0;
  int checks = 0;
  int stall_cyc;

  mem_stage_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
  endtask

  task automatic drive_store(input logic [15:0] a, input logic [15:0] d);
    ex_valid  = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
  endtask

  task automatic drive_load(input logic [15:0] a);
    ex_valid  = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = a;
    wdata     = '0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, {31'b0, mem_req}, 1);
  endtask

  // Wait for a write request, check it against the expected head entry, ack it.
  task automatic ack_store(input logic [15:0] a, input logic [15:0] d);
    wait_req("st");
    chk("st_we", {31'b0, mem_we}, 1);
    chk("st_addr", {16'b0, mem_addr}, {16'b0, a});
    chk("st_data", {16'b0, mem_wdata}, {16'b0, d});
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_drop", {31'b0, mem_req}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    idle_in();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_rvalid", {31'b0, rdata_valid}, 0);
    chk("rst_rdata", {16'b0, rdata}, 0);
    chk("rst_count", {29'b0, sb_count}, 0);
    tick();

    // Load 0x0010, memory acks 3 cycles after mem_req rises.
    stall_cyc = 0;
    drive_load(16'h0010);
    #1;
    chk("ld_stall_t0", {31'b0, stall}, 1);
    chk("ld_noreq_t0", {31'b0, mem_req}, 0);
    stall_cyc += int'(stall);
    tick();
    chk("ld_req", {31'b0, mem_req}, 1);
    chk("ld_we", {31'b0, mem_we}, 0);
    chk("ld_addr", {16'b0, mem_addr}, 32'h0010);
    stall_cyc += int'(stall);
    tick(); stall_cyc += int'(stall);
    tick(); stall_cyc += int'(stall);
    tick(); stall_cyc += int'(stall);
    chk("ld_req_held", {31'b0, mem_req}, 1);
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    #1;
    stall_cyc += int'(stall);
    chk("ld_stall_cycles", stall_cyc, 5);
    chk("ld_rvalid", {31'b0, rdata_valid}, 1);
    chk("ld_rdata", {16'b0, rdata}, 32'hBEEF);
    chk("ld_req_drop", {31'b0, mem_req}, 0);
    tick();
    idle_in();
    #1;
    chk("ld_rvalid_pulse", {31'b0, rdata_valid}, 0);
    chk("ld_stall_after", {31'b0, stall}, 0);
    tick();

    // Five back-to-back stores, no ack until the buffer is full.
    for (int i = 0; i < 4; i++) begin
      drive_store(16'h0100 + 16'(2 * i), 16'h00A0 + 16'(i));
      #1;
      chk("st_nostall", {31'b0, stall}, 0);
      tick();
    end
    drive_store(16'h0108, 16'h00A4);
    #1;
    chk("sb_full_count", {29'b0, sb_count}, 4);
    chk("st5_stall", {31'b0, stall}, 1);
    tick();
    chk("st5_stall_hold", {31'b0, stall}, 1);
    chk("sb_head_addr", {16'b0, mem_addr}, 32'h0100);
    chk("sb_head_data", {16'b0, mem_wdata}, 32'h00A0);
    chk("sb_head_we", {31'b0, mem_we}, 1);
    mem_ack = 1'b1;
    #1;
    chk("st5_release", {31'b0, stall}, 0);
    tick();
    mem_ack = 1'b0;
    idle_in();
    #1;
    chk("sb_pop_enq_count", {29'b0, sb_count}, 4);
    chk("sb_req_drop", {31'b0, mem_req}, 0);
    for (int i = 1; i < 5; i++) ack_store(16'h0100 + 16'(2 * i), 16'h00A0 + 16'(i));
    chk("sb_drained", {29'b0, sb_count}, 0);
    tick();

    // Store then immediate load to the same address.
    drive_store(16'h0020, 16'h1234);
    #1;
    chk("raw_st_nostall", {31'b0, stall}, 0);
    tick();
    drive_load(16'h0020);
    #1;
    chk("raw_ld_stall", {31'b0, stall}, 1);
    tick();
`ifdef MEM_STORE_FWD_EN
    chk("fwd_stall_done", {31'b0, stall}, 0);
    chk("fwd_rvalid", {31'b0, rdata_valid}, 1);
    chk("fwd_rdata", {16'b0, rdata}, 32'h1234);
    chk("fwd_no_read", {31'b0, mem_req & ~mem_we}, 0);
    tick();
    idle_in();
    ack_store(16'h0020, 16'h1234);
`else
    chk("raw_stall_drain", {31'b0, stall}, 1);
    ack_store(16'h0020, 16'h1234);
    chk("raw_stall_after_ack", {31'b0, stall}, 1);
    chk("raw_count", {29'b0, sb_count}, 0);
    tick();
    chk("raw_rd_req", {31'b0, mem_req}, 1);
    chk("raw_rd_we", {31'b0, mem_we}, 0);
    chk("raw_rd_addr", {16'b0, mem_addr}, 32'h0020);
    mem_ack = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    #1;
    chk("raw_stall_done", {31'b0, stall}, 0);
    chk("raw_rvalid", {31'b0, rdata_valid}, 1);
    chk("raw_rdata", {16'b0, rdata}, 32'h1234);
    tick();
    idle_in();
`endif
    tick();

    // Buffered store to 0x0040, load to 0x0050 takes the port first.
    drive_store(16'h0040, 16'h5555);
    tick();
    drive_load(16'h0050);
    #1;
    chk("pri_ld_stall", {31'b0, stall}, 1);
    tick();
    chk("pri_req", {31'b0, mem_req}, 1);
    chk("pri_we", {31'b0, mem_we}, 0);
    chk("pri_addr", {16'b0, mem_addr}, 32'h0050);
    chk("pri_count", {29'b0, sb_count}, 1);
    mem_ack = 1'b1;
    mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    #1;
    chk("pri_rvalid", {31'b0, rdata_valid}, 1);
    chk("pri_rdata", {16'b0, rdata}, 32'h7777);
    chk("pri_stall_done", {31'b0, stall}, 0);
    tick();
    idle_in();
    ack_store(16'h0040, 16'h5555);
    chk("pri_drained", {29'b0, sb_count}, 0);
    tick();

    // Reset during STORE_WAIT with two entries buffered.
    drive_store(16'h0080, 16'h0001);
    tick();
    drive_store(16'h0082, 16'h0002);
    tick();
    idle_in();
    #1;
    chk("rs_req_before", {31'b0, mem_req}, 1);
    chk("rs_count_before", {29'b0, sb_count}, 2);
    rst = 1'b1;
    #1;
    chk("rs_req_async", {31'b0, mem_req}, 0);
    chk("rs_count_async", {29'b0, sb_count}, 0);
    tick();
    rst = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rs_late_ack_rvalid", {31'b0, rdata_valid}, 0);
    chk("rs_late_ack_req", {31'b0, mem_req}, 0);
    tick();
    chk("rs_stay_idle", {31'b0, mem_req}, 0);
    chk("rs_count_after", {29'b0, sb_count}, 0);

    // mem_read and mem_write together behave as a load only.
    ex_valid  = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    addr      = 16'h0060;
    wdata     = 16'h9999;
    #1;
    chk("rw_stall", {31'b0, stall}, 1);
    tick();
    chk("rw_req", {31'b0, mem_req}, 1);
    chk("rw_we", {31'b0, mem_we}, 0);
    chk("rw_addr", {16'b0, mem_addr}, 32'h0060);
    chk("rw_count", {29'b0, sb_count}, 0);
    mem_ack = 1'b1;
    mem_rdata = 16'h4242;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    #1;
    chk("rw_rvalid", {31'b0, rdata_valid}, 1);
    chk("rw_rdata", {16'b0, rdata}, 32'h4242);
    chk("rw_stall_done", {31'b0, stall}, 0);
    tick();
    idle_in();
    tick();
    tick();
    chk("rw_no_write_req", {31'b0, mem_req}, 0);
    chk("rw_count_after", {29'b0, sb_count}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
